// File: rtl/tick_gen_multi.sv
// rtl/tick_gen_multi.sv - multi-channel programmable tick generator
// Per-channel divisor counters with staged reconfiguration, one-shot mode and square-wave outputs.
module tick_gen_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [4:0]       NUM_CH_L = 5'(NUM_CH);

  logic [CNT_W-1:0] cnt_q  [NUM_CH];
  logic [CNT_W-1:0] cnt_d  [NUM_CH];
  logic [CNT_W-1:0] div_q  [NUM_CH];
  logic [CNT_W-1:0] div_d  [NUM_CH];
  logic [CNT_W-1:0] pdiv_q [NUM_CH];
  logic [CNT_W-1:0] pdiv_d [NUM_CH];

  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] pmode_q, pmode_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic [NUM_CH-1:0] wrap;
  logic              cfg_err_q, cfg_err_d;
  logic              cfg_bad, cfg_ok;

  always_comb begin
    cfg_bad   = cfg_wr && (({1'b0, cfg_ch} >= NUM_CH_L) || (cfg_div == '0));
    cfg_ok    = cfg_wr && !cfg_bad;
    cfg_err_d = cfg_bad;
    wrap      = '0;
    mode_d    = mode_q;
    pmode_d   = pmode_q;
    pend_d    = pend_q;
    done_d    = done_q;
    sq_d      = sq_q;
    tick_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      pdiv_d[i] = pdiv_q[i];
      wrap[i]   = en[i] && !done_q[i] && (cnt_q[i] == div_q[i] - CNT_W'(1));
      tick_d[i] = wrap[i];

      if (!en[i]) begin
        cnt_d[i]  = '0;
        sq_d[i]   = 1'b0;
        done_d[i] = 1'b0;
      end else if (done_q[i]) begin
        cnt_d[i] = '0;
      end else if (wrap[i]) begin
        cnt_d[i]  = '0;
        sq_d[i]   = ~sq_q[i];
        done_d[i] = mode_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

      // Only registered pending values are applied, so a write landing on a wrap waits one period.
      if (pend_q[i] && (wrap[i] || !en[i] || done_q[i])) begin
        div_d[i]  = pdiv_q[i];
        mode_d[i] = pmode_q[i];
        pend_d[i] = 1'b0;
      end
      if (cfg_ok && (cfg_ch == 4'(i))) begin
        pdiv_d[i]  = cfg_div;
        pmode_d[i] = cfg_oneshot;
        pend_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DIV_RST;
        pdiv_q[i] <= DIV_RST;
      end
      mode_q    <= '0;
      pmode_q   <= '0;
      pend_q    <= '0;
      done_q    <= '0;
      tick_q    <= '0;
      sq_q      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pdiv_q[i] <= pdiv_d[i];
      end
      mode_q    <= mode_d;
      pmode_q   <= pmode_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign tick    = tick_q;
  assign sq      = sq_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: doc/tick_gen_multi.md
TICK_GEN_MULTI -- requirements
Module: tick_gen_multi

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, giving the number of independent tick channels (1..16).
REQ-002 The module SHALL have parameter CNT_W, default 27, giving the divisor and counter width in bits.
REQ-003 The module SHALL have parameter DEFAULT_DIV, default 100_000_000, giving the reset divisor of every channel (1..2^CNT_W-1).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-006 The module SHALL have port en, input, NUM_CH bits: per-channel enable.
REQ-007 The module SHALL have port cfg_wr, input, 1 bit: configuration write strobe, valid for one cycle.
REQ-008 The module SHALL have port cfg_ch, input, 4 bits: target channel index.
REQ-009 The module SHALL have port cfg_div, input, CNT_W bits: new divisor (period in clk cycles).
REQ-010 The module SHALL have port cfg_oneshot, input, 1 bit: new mode (1 = one-shot, 0 = periodic).
REQ-011 The module SHALL have port cfg_err, output, 1 bit: one-cycle pulse flagging a rejected write.
REQ-012 The module SHALL have port tick, output, NUM_CH bits: registered one-cycle pulse per channel.
REQ-013 The module SHALL have port sq, output, NUM_CH bits: registered square wave per channel, toggling on each tick.

Function
REQ-014 Each channel SHALL hold a counter, an active divisor, an active mode, a pending divisor/mode, a pending flag, and a done flag.
REQ-015 While en[i]=1 and done=0, the counter SHALL increment each cycle; on the cycle it equals active divisor-1, it SHALL reset to 0 and tick[i] SHALL be 1 in the following cycle.
REQ-016 After en[i] rises, the first tick SHALL occur exactly D cycles later; subsequent ticks SHALL occur every D cycles (D = active divisor).
REQ-017 D=1 SHALL produce tick[i]=1 on every cycle while enabled.
REQ-018 sq[i] SHALL toggle in the same cycle as each tick[i] pulse.
REQ-019 While en[i]=0, the counter, tick[i], sq[i] and done SHALL be held at 0.
REQ-020 In one-shot mode, a channel SHALL emit exactly one tick, then set done and hold the counter at 0; it re-arms only when en[i] goes low for at least one cycle.
REQ-021 A cfg_wr with cfg_ch<NUM_CH and cfg_div!=0 SHALL load the pending divisor/mode and set the pending flag; a later write before application SHALL overwrite it.
REQ-022 A cfg_wr with cfg_ch>=NUM_CH or cfg_div=0 SHALL change no state and SHALL pulse cfg_err one cycle later.
REQ-023 The pending values SHALL become active, and the pending flag SHALL clear, on the next counter wrap cycle, or on the next cycle if en[i]=0 or done=1.
REQ-024 A write in the same cycle as a wrap SHALL not be applied by that wrap; it SHALL be applied at the following wrap.
REQ-025 Changing the divisor SHALL never shorten the period in progress and SHALL never produce a glitch or double tick.
REQ-026 Channels SHALL be fully independent; simultaneous ticks on several channels SHALL all be asserted.

Reset
REQ-027 While rst=0: all counters=0, active divisor=DEFAULT_DIV, mode=periodic, pending=0, done=0, tick=0, sq=0, cfg_err=0.
REQ-028 Reset asserted mid-period SHALL abort the period; after rst returns to 1 with en=1, the first tick SHALL occur DEFAULT_DIV cycles later.

Verification
REQ-029 DEFAULT_DIV=10, en[0]=1 after reset -> tick[0] pulses at cycles 10, 20 and 30; sq[0] = 1, 0, 1.
REQ-030 Write div=4 to ch1 at cycle 3 of a 10-cycle period -> the current period ends at 10; the next ticks follow at +4 and +8.
REQ-031 One-shot, div=5 on ch2 -> one tick at cycle 5, none through cycle 50; en[2] low for 1 cycle then high -> tick 5 cycles later.
REQ-032 cfg_ch=NUM_CH, or cfg_div=0 -> cfg_err pulses 1 cycle; all channel timing is unchanged.
REQ-033 Div=1 on ch3 -> tick[3]=1 every cycle and sq[3] toggles every cycle; rst=0 mid-run -> all outputs are 0 in the next cycle.
